// File: rtl/bp_resolve_queue.sv
// In-order branch resolution queue feeding the 2-bit predictor table write port.
// Optional statistics counters are enabled with `define BPQ_STATS_EN.
module bp_resolve_queue #(
    parameter int IDX_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [IDX_W-1:0]             push_idx,
    input  logic                         push_pred,
    input  logic                         res_valid,
    input  logic                         res_taken,
    input  logic                         flush,
    output logic [IDX_W-1:0]             w_addr,
    output logic                         did_branch,
    output logic                         we,
    output logic                         mispredict,
    output logic                         res_err,
    output logic [$clog2(DEPTH):0]       count
`ifdef BPQ_STATS_EN
    ,
    output logic [15:0]                  stat_resolved,
    output logic [15:0]                  stat_mispred
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [IDX_W-1:0] idx_mem_r [DEPTH];
    logic [DEPTH-1:0] pred_mem_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_s;
    logic [PW-1:0]    rd_ptr_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_s;
    logic             push_ready_s;
    logic             push_fire_s;
    logic             res_fire_s;
    logic             res_err_s;
    logic             mispredict_s;
    logic             rd_pred_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic [IDX_W-1:0] w_addr_r;
    logic             did_branch_r;
    logic             we_r;
    logic             mispredict_r;
    logic             res_err_r;

    // Handshake qualification; push_ready depends on occupancy only, never on res_valid.
    always_comb begin
        push_ready_s = (count_r < CW'(DEPTH));
        push_fire_s  = push_valid && push_ready_s && !flush;
        res_fire_s   = res_valid && (count_r != {CW{1'b0}});
        res_err_s    = res_valid && (count_r == {CW{1'b0}});
        rd_idx_s     = idx_mem_r[rd_ptr_r];
        rd_pred_s    = pred_mem_r[rd_ptr_r];
        mispredict_s = res_fire_s && (rd_pred_s != res_taken);
    end

    // Next pointer and occupancy; flush wins over any same-cycle push.
    always_comb begin
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        count_s  = count_r;
        if (flush) begin
            wr_ptr_s = {PW{1'b0}};
            rd_ptr_s = {PW{1'b0}};
            count_s  = {CW{1'b0}};
        end else begin
            if (push_fire_s) begin
                wr_ptr_s = wr_ptr_r + PW'(1'b1);
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (res_fire_s) begin
                rd_ptr_s = rd_ptr_r + PW'(1'b1);
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            case ({push_fire_s, res_fire_s})
                2'b10:   count_s = count_r + CW'(1'b1);
                2'b01:   count_s = count_r - CW'(1'b1);
                default: count_s = count_r;
            endcase
        end
    end

    // Entry storage; stale contents are harmless because pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_fire_s) begin
            idx_mem_r[wr_ptr_r]  <= push_idx;
            pred_mem_r[wr_ptr_r] <= push_pred;
        end
    end

    // Queue state and registered predictor-update outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            w_addr_r     <= {IDX_W{1'b0}};
            did_branch_r <= 1'b0;
            we_r         <= 1'b0;
            mispredict_r <= 1'b0;
            res_err_r    <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            count_r      <= count_s;
            we_r         <= res_fire_s;
            mispredict_r <= mispredict_s;
            res_err_r    <= res_err_s;
            if (res_fire_s) begin
                w_addr_r     <= rd_idx_s;
                did_branch_r <= res_taken;
            end
        end
    end

    assign push_ready = push_ready_s;
    assign count      = count_r;
    assign w_addr     = w_addr_r;
    assign did_branch = did_branch_r;
    assign we         = we_r;
    assign mispredict = mispredict_r;
    assign res_err    = res_err_r;

`ifdef BPQ_STATS_EN
    logic [15:0] stat_resolved_r;
    logic [15:0] stat_mispred_r;

    // Saturating event counters; cleared only by reset, flush leaves them intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_resolved_r <= 16'h0000;
            stat_mispred_r  <= 16'h0000;
        end else begin
            if (res_fire_s && (stat_resolved_r != 16'hFFFF)) begin
                stat_resolved_r <= stat_resolved_r + 16'h0001;
            end
            if (mispredict_s && (stat_mispred_r != 16'hFFFF)) begin
                stat_mispred_r <= stat_mispred_r + 16'h0001;
            end
        end
    end

    assign stat_resolved = stat_resolved_r;
    assign stat_mispred  = stat_mispred_r;
`endif

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Self-checking bench for bp_resolve_queue: directed vector table, wrap-around
// sequence, and randomized traffic against a queue-based reference model.
module tb_bp_resolve_queue;

    localparam int IDX_W = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             push_valid;
    logic             push_ready;
    logic [IDX_W-1:0] push_idx;
    logic             push_pred;
    logic             res_valid;
    logic             res_taken;
    logic             flush;
    logic [IDX_W-1:0] w_addr;
    logic             did_branch;
    logic             we;
    logic             mispredict;
    logic             res_err;
    logic [2:0]       count;
`ifdef BPQ_STATS_EN
    logic [15:0]      stat_resolved;
    logic [15:0]      stat_mispred;
`endif

    int errors = 0;
    int checks = 0;

    bp_resolve_queue #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_idx(push_idx), .push_pred(push_pred),
        .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
        .w_addr(w_addr), .did_branch(did_branch), .we(we),
        .mispredict(mispredict), .res_err(res_err), .count(count)
`ifdef BPQ_STATS_EN
        , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, pv;
        logic [7:0] pi;
        logic       pp, rv, rt, fl;
        logic       we;
        logic [7:0] wa;
        logic       did, mis, err;
        logic [2:0] cnt;
        logic       rdy;
    } vec_t;

    typedef struct {
        logic [7:0] idx;
        logic       pred;
    } ent_t;

    vec_t vecs[$];
    ent_t mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic pv, input logic [7:0] pi, input logic pp,
                         input logic rv, input logic rt, input logic fl);
        rst = r; push_valid = pv; push_idx = pi; push_pred = pp;
        res_valid = rv; res_taken = rt; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic pv, input logic [7:0] pi, input logic pp,
                       input logic rv, input logic rt, input logic fl,
                       input logic e_we, input logic [7:0] e_wa, input logic e_did,
                       input logic e_mis, input logic e_err, input logic [2:0] e_cnt,
                       input logic e_rdy);
        vec_t v;
        v.r = r; v.pv = pv; v.pi = pi; v.pp = pp; v.rv = rv; v.rt = rt; v.fl = fl;
        v.we = e_we; v.wa = e_wa; v.did = e_did; v.mis = e_mis; v.err = e_err;
        v.cnt = e_cnt; v.rdy = e_rdy;
        vecs.push_back(v);
    endtask

    initial begin
        logic       e_we, e_mis, e_err, m_did, pv, pp, rv, rt, fl, r;
        logic [7:0] m_addr, pi;
        int         pre;
        ent_t       ent;

        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        //  r  pv  idx    pp rv rt fl | we addr  did mis err cnt rdy
        add(1, 0, 8'h00, 0, 0, 0, 0,   0, 8'h00, 0, 0, 0, 3'd0, 1);
        add(1, 0, 8'h00, 0, 0, 0, 0,   0, 8'h00, 0, 0, 0, 3'd0, 1);
        add(1, 0, 8'h00, 0, 0, 0, 0,   0, 8'h00, 0, 0, 0, 3'd0, 1);
        add(0, 0, 8'h00, 0, 0, 0, 0,   0, 8'h00, 0, 0, 0, 3'd0, 1);
        add(0, 0, 8'h00, 0, 1, 1, 0,   0, 8'h00, 0, 0, 1, 3'd0, 1);  // resolve on empty
        add(0, 1, 8'h05, 0, 0, 0, 0,   0, 8'h00, 0, 0, 0, 3'd1, 1);
        add(0, 0, 8'h00, 0, 1, 1, 0,   1, 8'h05, 1, 1, 0, 3'd0, 1);
        add(0, 0, 8'h00, 0, 0, 0, 0,   0, 8'h05, 1, 0, 0, 3'd0, 1);
        add(0, 1, 8'h10, 1, 0, 0, 0,   0, 8'h05, 1, 0, 0, 3'd1, 1);
        add(0, 1, 8'h11, 1, 0, 0, 0,   0, 8'h05, 1, 0, 0, 3'd2, 1);
        add(0, 1, 8'h12, 1, 0, 0, 0,   0, 8'h05, 1, 0, 0, 3'd3, 1);
        add(0, 1, 8'h13, 1, 0, 0, 0,   0, 8'h05, 1, 0, 0, 3'd4, 0);
        add(0, 1, 8'h14, 1, 0, 0, 0,   0, 8'h05, 1, 0, 0, 3'd4, 0);  // refused when full
        add(0, 1, 8'h15, 1, 1, 1, 0,   1, 8'h10, 1, 0, 0, 3'd3, 1);  // full: push refused
        add(0, 0, 8'h00, 0, 1, 1, 0,   1, 8'h11, 1, 0, 0, 3'd2, 1);
        add(0, 0, 8'h00, 0, 1, 1, 0,   1, 8'h12, 1, 0, 0, 3'd1, 1);
        add(0, 0, 8'h00, 0, 1, 1, 0,   1, 8'h13, 1, 0, 0, 3'd0, 1);
        add(0, 0, 8'h00, 0, 0, 0, 0,   0, 8'h13, 1, 0, 0, 3'd0, 1);
        add(0, 1, 8'h20, 0, 0, 0, 0,   0, 8'h13, 1, 0, 0, 3'd1, 1);
        add(0, 1, 8'h21, 1, 0, 0, 0,   0, 8'h13, 1, 0, 0, 3'd2, 1);
        add(0, 1, 8'h22, 0, 0, 0, 0,   0, 8'h13, 1, 0, 0, 3'd3, 1);
        add(0, 1, 8'h30, 1, 1, 0, 1,   1, 8'h20, 0, 0, 0, 3'd0, 1);  // flush + resolve + push
        add(0, 0, 8'h00, 0, 1, 1, 0,   0, 8'h20, 0, 0, 1, 3'd0, 1);
        add(0, 1, 8'h40, 1, 0, 0, 0,   0, 8'h20, 0, 0, 0, 3'd1, 1);
        add(1, 0, 8'h00, 0, 1, 0, 0,   0, 8'h00, 0, 0, 0, 3'd0, 1);  // reset beats resolve
        add(0, 0, 8'h00, 0, 1, 0, 0,   0, 8'h00, 0, 0, 1, 3'd0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].pv, vecs[i].pi, vecs[i].pp, vecs[i].rv, vecs[i].rt, vecs[i].fl);
            tick();
            chk($sformatf("v%0d_we", i), {31'd0, we}, {31'd0, vecs[i].we});
            chk($sformatf("v%0d_w_addr", i), {24'd0, w_addr}, {24'd0, vecs[i].wa});
            chk($sformatf("v%0d_did_branch", i), {31'd0, did_branch}, {31'd0, vecs[i].did});
            chk($sformatf("v%0d_mispredict", i), {31'd0, mispredict}, {31'd0, vecs[i].mis});
            chk($sformatf("v%0d_res_err", i), {31'd0, res_err}, {31'd0, vecs[i].err});
            chk($sformatf("v%0d_count", i), {29'd0, count}, {29'd0, vecs[i].cnt});
            chk($sformatf("v%0d_push_ready", i), {31'd0, push_ready}, {31'd0, vecs[i].rdy});
        end

        // Wrap-around: one entry kept queued while pushing and resolving together.
        drive(1'b0, 1'b1, 8'h50, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("wrap_prime_count", {29'd0, count}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 8'h51 + 8'(i), 1'b0, 1'b1, 1'(i % 2), 1'b0);
            tick();
            chk($sformatf("wrap%0d_we", i), {31'd0, we}, 32'd1);
            chk($sformatf("wrap%0d_w_addr", i), {24'd0, w_addr}, 32'h50 + 32'(i));
            chk($sformatf("wrap%0d_mispredict", i), {31'd0, mispredict}, 32'(i % 2));
            chk($sformatf("wrap%0d_count", i), {29'd0, count}, 32'd1);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("wrap_drain_w_addr", {24'd0, w_addr}, 32'h5A);
        chk("wrap_drain_count", {29'd0, count}, 32'd0);

        // Randomized traffic against a FIFO reference model.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        mq.delete();
        m_addr = 8'h00;
        m_did  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 199) == 0);
            pv = ($urandom_range(0, 9) < 6);
            pi = 8'($urandom);
            pp = 1'($urandom);
            rv = ($urandom_range(0, 9) < 5);
            rt = 1'($urandom);
            fl = ($urandom_range(0, 29) == 0);
            drive(r, pv, pi, pp, rv, rt, fl);
            e_we = 1'b0; e_mis = 1'b0; e_err = 1'b0;
            if (r) begin
                mq.delete();
                m_addr = 8'h00;
                m_did  = 1'b0;
            end else begin
                pre = mq.size();
                if (rv && pre > 0) begin
                    ent    = mq.pop_front();
                    e_we   = 1'b1;
                    m_addr = ent.idx;
                    m_did  = rt;
                    e_mis  = (ent.pred != rt);
                end else if (rv) begin
                    e_err = 1'b1;
                end
                if (fl) begin
                    mq.delete();
                end else if (pv && pre < DEPTH) begin
                    ent.idx = pi; ent.pred = pp;
                    mq.push_back(ent);
                end
            end
            tick();
            chk("rnd_we", {31'd0, we}, {31'd0, e_we});
            chk("rnd_w_addr", {24'd0, w_addr}, {24'd0, m_addr});
            chk("rnd_did_branch", {31'd0, did_branch}, {31'd0, m_did});
            chk("rnd_mispredict", {31'd0, mispredict}, {31'd0, e_mis});
            chk("rnd_res_err", {31'd0, res_err}, {31'd0, e_err});
            chk("rnd_count", {29'd0, count}, 32'(mq.size()));
            chk("rnd_push_ready", {31'd0, push_ready}, {31'd0, (mq.size() < DEPTH)});
        end

`ifdef BPQ_STATS_EN
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("stat_reset_resolved", {16'd0, stat_resolved}, 32'd0);
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b1, 8'(i), (i < 7) ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, (i == 100));
            tick();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stat_resolved_300", {16'd0, stat_resolved}, 32'd300);
        chk("stat_mispred_7", {16'd0, stat_mispred}, 32'd7);
        drive(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        force dut.stat_resolved_r = 16'hFFFF;
        tick();
        release dut.stat_resolved_r;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stat_resolved_sat", {16'd0, stat_resolved}, 32'hFFFF);
        chk("stat_sat_we", {31'd0, we}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
